i3c_sync_msg_fifo: RTL
======================

# i3c_sync_msg_fifo

Single-clock, parametrised message FIFO for the I3C controller's CLK domain. It buffers data between register-side logic and the internal engines where no clock crossing is needed. Depth and data width are generic. Each entry carries an end-of-message tag, and the block tracks how many complete messages it holds. Both directions get programmable trigger interrupts, and overflow and underflow are recorded in sticky flags.

## Interface
Parameters:
- WIDTH, 8, data width in bits; legal range 1..32
- BITS, 3, depth is 2^BITS entries; legal range 2..6

Ports:
- CLK  in  1  system clock; all logic is on the rising edge
- RST  in  1  reset; asynchronous and active-high
- flush  in  1  synchronous clear of FIFO contents
- wr_valid  in  1  push request
- wr_data  in  WIDTH  push data
- wr_end  in  1  marks the pushed entry as the last of a message
- wr_ready  out  1  FIFO not full
- rd_valid  out  1  FIFO not empty
- rd_data  out  WIDTH  data at the head of the FIFO (first-word fall-through)
- rd_end  out  1  end tag of the head entry, gated by rd_valid
- rd_ack  in  1  pop request
- level  out  BITS+1  number of entries held, 0..2^BITS
- msg_cnt  out  BITS+1  number of end-tagged entries held
- tx_trig  in  2  threshold select for int_tx
- rx_trig  in  2  threshold select for int_rx
- int_tx  out  1  space-available interrupt, registered
- int_rx  out  1  data-available interrupt, registered
- ovf  out  1  sticky: a push was attempted while full
- udf  out  1  sticky: a pop was attempted while empty
- err_clr  in  1  clears ovf and udf

## Operation
Storage and pointers:
- Storage: 2^BITS × (WIDTH+1) bits, holding {end, data}.
- The write and read pointers are BITS+1 bits wide, with the MSB used as a wrap bit.
- Empty when the pointers are equal. Full when the MSBs differ and the low BITS bits are equal.

Push and pop:
- Push is accepted when wr_valid & ~full. The entry is written at wptr and wptr increments.
- wr_valid while full drops the data and sets ovf. This applies even if a pop is accepted in the same cycle; there is no full-bypass.
- Pop is accepted when rd_ack & ~empty, and rptr increments.
- rd_ack while empty sets udf. This applies even if a push is accepted in the same cycle; there is no empty-bypass.
- rd_data and rd_end are combinational from mem[rptr]. When empty, rd_data shows stale contents and rd_end is 0.

Counters:
- level is incremented on a push only, decremented on a pop only, and unchanged when both occur.
- level is computed as the wrapped difference wptr - rptr in BITS+1 bits; it never exceeds 2^BITS.
- msg_cnt increments on an accepted push with wr_end=1 and decrements on an accepted pop with rd_end=1. When both occur in the same cycle, msg_cnt is unchanged.

Flush:
- flush=1 clears the pointers, level and msg_cnt on the next edge.
- flush has priority over any simultaneous push or pop. That push or pop is ignored and does not set ovf or udf.
- Memory contents and the sticky flags are not cleared by flush.

Sticky flags:
- err_clr clears ovf and udf.
- If a set condition occurs in the same cycle as err_clr, the flag is set (set wins).

int_rx is registered and is the next-state value of:
- 0 if level == 0;
- else 1 if msg_cnt != 0;
- else level >= R, where R = 1, 2^BITS/4, 2^BITS/2, 3·2^BITS/4 for rx_trig = 00, 01, 10, 11.

int_tx is registered and is the next-state value of:
- 0 if full;
- else 1 if level == 0;
- else by tx_trig: 00 gives 0; 01 gives level <= 2^BITS/4; 10 gives level <= 2^BITS/2; 11 gives 1.

In both interrupts, "next-state" means the value computed from level and msg_cnt after the current edge, so the interrupt updates on the same edge as the counters.

## Timing
Reset values:
- RST=1 asynchronously clears the pointers, level, msg_cnt, ovf, udf, int_rx, memory, and sets int_tx to 1.
- While RST is held: wr_ready=1, rd_valid=0, rd_end=0, rd_data=0.

Latency:
- A pushed entry is visible on rd_valid and rd_data in the cycle after the accepting edge (1-cycle push-to-pop latency).
- wr_ready rises in the cycle after the pop edge that frees a slot.
- level, msg_cnt, int_tx and int_rx update on the same edge as the accepted push or pop.

Flush:
- After the flush edge, the FIFO is empty, int_tx=1 and int_rx=0.

Reset mid-operation:
- Reset during a push or pop discards everything held; no partial entry survives.

Wrap-around:
- The pointers wrap modulo 2^(BITS+1).
- Full and empty detection must be correct across every wrap.

## Test plan
- Reset with BITS=3, WIDTH=8:
  - Assert RST mid-run → level=0, msg_cnt=0, wr_ready=1, rd_valid=0, int_tx=1, int_rx=0, ovf=udf=0.
- Fill and overflow:
  - Push 8 bytes 0x10..0x17, then push 0x18 while full → level=8, wr_ready=0, ovf=1, int_tx=0.
  - Pop all 8 → data 0x10..0x17 in order; 0x18 never appears.
- Wrap-around:
  - Repeat 20 cycles of push-then-pop, then 5 pushes and 3 pops → level=2, rd_data equals the 4th byte of the final 5 pushes.
- Message tracking:
  - Push 3 bytes with wr_end on the 3rd, rx_trig=11 → int_rx=1 after the 3rd push (msg_cnt=1, level=3 < 6).
  - Pop 3 → rd_end=1 on the 3rd byte only; msg_cnt=0, int_rx=0.
- Thresholds:
  - tx_trig=01 → int_tx is 1 at level 0..2 and 0 at level 3.
  - rx_trig=10 → int_rx is 0 at level 3 and 1 at level 4.
- Corner cases:
  - Push and pop in the same cycle while empty → udf=1, level=1.
  - flush together with push → level=0, ovf unchanged.
  - err_clr together with an ovf condition → ovf stays 1.

Source files
------------

// File: rtl/i3c_sync_msg_fifo_if.sv
// ============================================================================
// Module   : i3c_sync_msg_fifo_if
// Brief    : Push/pop, status and interrupt bundle of the single-clock message FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i3c_sync_msg_fifo_if #(
    parameter int WIDTH = 8,
    parameter int BITS  = 3
);
    logic             flush;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_end;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_end;
    logic             rd_ack;
    logic [BITS:0]    level;
    logic [BITS:0]    msg_cnt;
    logic [1:0]       tx_trig;
    logic [1:0]       rx_trig;
    logic             int_tx;
    logic             int_rx;
    logic             ovf;
    logic             udf;
    logic             err_clr;

    modport slave (
        input  flush, wr_valid, wr_data, wr_end, rd_ack, tx_trig, rx_trig, err_clr,
        output wr_ready, rd_valid, rd_data, rd_end, level, msg_cnt,
               int_tx, int_rx, ovf, udf
    );

    modport master (
        output flush, wr_valid, wr_data, wr_end, rd_ack, tx_trig, rx_trig, err_clr,
        input  wr_ready, rd_valid, rd_data, rd_end, level, msg_cnt,
               int_tx, int_rx, ovf, udf
    );
endinterface

`default_nettype wire

// File: rtl/i3c_sync_msg_fifo.sv
// ============================================================================
// Module   : i3c_sync_msg_fifo
// Brief    : Single-clock FWFT message FIFO with end tags, message count,
//            trigger interrupts and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i3c_sync_msg_fifo #(
    parameter int WIDTH = 8,
    parameter int BITS  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    i3c_sync_msg_fifo_if.slave   bus
);

    localparam int            DEPTH   = 1 << BITS;
    localparam logic [BITS:0] C_ZERO  = '0;
    localparam logic [BITS:0] C_ONE   = {{BITS{1'b0}}, 1'b1};
    localparam logic [BITS:0] C_FULL  = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0] C_HALF  = C_FULL >> 1;
    localparam logic [BITS:0] C_QTR   = C_FULL >> 2;
    localparam logic [BITS:0] C_3QTR  = C_QTR + C_HALF;

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [BITS:0]   r_wptr;
    logic [BITS:0]   r_rptr;
    logic [BITS:0]   r_level;
    logic [BITS:0]   r_msg_cnt;
    logic            r_int_tx;
    logic            r_int_rx;
    logic            r_ovf;
    logic            r_udf;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_udf_set;
    logic [WIDTH:0]  w_head;
    logic [BITS:0]   w_wptr_nxt;
    logic [BITS:0]   w_rptr_nxt;
    logic [BITS:0]   w_level_nxt;
    logic [BITS:0]   w_msg_nxt;
    logic [BITS:0]   w_rx_thr;
    logic            w_int_tx_nxt;
    logic            w_int_rx_nxt;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[BITS] != r_rptr[BITS]) &&
                     (r_wptr[BITS-1:0] == r_rptr[BITS-1:0]);
    assign w_head  = r_mem[r_rptr[BITS-1:0]];

    // flush swallows any same-cycle push/pop, including its error side effects
    assign w_push    = bus.wr_valid & ~w_full  & ~bus.flush;
    assign w_pop     = bus.rd_ack   & ~w_empty & ~bus.flush;
    assign w_ovf_set = bus.wr_valid &  w_full  & ~bus.flush;
    assign w_udf_set = bus.rd_ack   &  w_empty & ~bus.flush;

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_msg_nxt  = r_msg_cnt;
        if (bus.flush) begin
            w_wptr_nxt = C_ZERO;
            w_rptr_nxt = C_ZERO;
            w_msg_nxt  = C_ZERO;
        end else begin
            if (w_push) w_wptr_nxt = r_wptr + C_ONE;
            if (w_pop)  w_rptr_nxt = r_rptr + C_ONE;
            case ({w_push & bus.wr_end, w_pop & w_head[WIDTH]})
                2'b10:   w_msg_nxt = r_msg_cnt + C_ONE;
                2'b01:   w_msg_nxt = r_msg_cnt - C_ONE;
                default: w_msg_nxt = r_msg_cnt;
            endcase
        end
        w_level_nxt = w_wptr_nxt - w_rptr_nxt;
    end

    always_comb begin
        case (bus.rx_trig)
            2'b00:   w_rx_thr = C_ONE;
            2'b01:   w_rx_thr = C_QTR;
            2'b10:   w_rx_thr = C_HALF;
            default: w_rx_thr = C_3QTR;
        endcase

        if (w_level_nxt == C_ZERO)     w_int_rx_nxt = 1'b0;
        else if (w_msg_nxt != C_ZERO)  w_int_rx_nxt = 1'b1;
        else                           w_int_rx_nxt = (w_level_nxt >= w_rx_thr);

        if (w_level_nxt == C_FULL)      w_int_tx_nxt = 1'b0;
        else if (w_level_nxt == C_ZERO) w_int_tx_nxt = 1'b1;
        else begin
            case (bus.tx_trig)
                2'b00:   w_int_tx_nxt = 1'b0;
                2'b01:   w_int_tx_nxt = (w_level_nxt <= C_QTR);
                2'b10:   w_int_tx_nxt = (w_level_nxt <= C_HALF);
                default: w_int_tx_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr    <= C_ZERO;
            r_rptr    <= C_ZERO;
            r_level   <= C_ZERO;
            r_msg_cnt <= C_ZERO;
            r_int_tx  <= 1'b1;
            r_int_rx  <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_push) r_mem[r_wptr[BITS-1:0]] <= {bus.wr_end, bus.wr_data};
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_level   <= w_level_nxt;
            r_msg_cnt <= w_msg_nxt;
            r_int_tx  <= w_int_tx_nxt;
            r_int_rx  <= w_int_rx_nxt;
            r_ovf     <= w_ovf_set | (r_ovf & ~bus.err_clr);
            r_udf     <= w_udf_set | (r_udf & ~bus.err_clr);
        end
    end

    assign bus.wr_ready = ~w_full;
    assign bus.rd_valid = ~w_empty;
    assign bus.rd_data  = w_head[WIDTH-1:0];
    assign bus.rd_end   = w_head[WIDTH] & ~w_empty;
    assign bus.level    = r_level;
    assign bus.msg_cnt  = r_msg_cnt;
    assign bus.int_tx   = r_int_tx;
    assign bus.int_rx   = r_int_rx;
    assign bus.ovf      = r_ovf;
    assign bus.udf      = r_udf;

endmodule

`default_nettype wire
